// File: rtl/alu_muldiv_pkg.sv
// Shared funct codes and FSM state encoding for the HI/LO multiply/divide unit.
package alu_muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply or
// restoring divide on the {accHi, accLo} accumulator pair.
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic              is_div_i,
    input  logic [DATA_W-1:0] acc_hi_i,
    input  logic [DATA_W-1:0] acc_lo_i,
    input  logic [DATA_W-1:0] operand_i,
    output logic [DATA_W-1:0] acc_hi_o,
    output logic [DATA_W-1:0] acc_lo_o
);

    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   mulSum;
    logic [DATA_W:0]   divTrial;
    logic [DATA_W:0]   divDiff;

    // The partial remainder is always below the divisor, so the W+1 bit
    // trial difference borrows exactly when the subtraction must be undone.
    always_comb begin
        addend   = acc_lo_i[0] ? operand_i : '0;
        mulSum   = {1'b0, acc_hi_i} + {1'b0, addend};
        divTrial = {acc_hi_i, acc_lo_i[DATA_W-1]};
        divDiff  = divTrial - {1'b0, operand_i};
        if (is_div_i) begin
            acc_hi_o = divDiff[DATA_W] ? divTrial[DATA_W-1:0] : divDiff[DATA_W-1:0];
            acc_lo_o = {acc_lo_i[DATA_W-2:0], ~divDiff[DATA_W]};
        end else begin
            acc_hi_o = mulSum[DATA_W:1];
            acc_lo_o = {mulSum[0], acc_lo_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative HI/LO multiply/divide unit with MFHI/MFLO/MTHI/MTLO handling;
// MULT/DIV take DATA_W cycles and interlock issue via issue_ready.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    output logic               busy,
    output logic               result_valid,
    output logic [DATA_W-1:0]  result,
    output logic [DATA_W-1:0]  hi_out,
    output logic [DATA_W-1:0]  lo_out,
    output logic               div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
    logic [DATA_W-1:0] accHi_q, accHi_d, accLo_q, accLo_d, operand_q, operand_d;
    logic              negLo_q, negLo_d, negHi_q, negHi_d;
    logic              resultValid_q, resultValid_d, divByZero_q, divByZero_d;

    logic                accept, isSigned, rsNeg, rtNeg;
    logic [DATA_W-1:0]   rsMag, rtMag, iterHi, iterLo;
    logic [2*DATA_W-1:0] product;

    muldiv_iter #(.DATA_W(DATA_W)) u_iter (
        .is_div_i  (state_q == ST_DIV),
        .acc_hi_i  (accHi_q),
        .acc_lo_i  (accLo_q),
        .operand_i (operand_q),
        .acc_hi_o  (iterHi),
        .acc_lo_o  (iterLo)
    );

    // Operands are reduced to magnitudes at issue; signs are fixed up once at the end.
    always_comb begin
        accept   = issue_valid && (state_q == ST_IDLE);
        isSigned = (funct == FUNCT_W'(FN_MULT)) || (funct == FUNCT_W'(FN_DIV));
        rsNeg    = isSigned && rs_data[DATA_W-1];
        rtNeg    = isSigned && rt_data[DATA_W-1];
        rsMag    = rsNeg ? -rs_data : rs_data;
        rtMag    = rtNeg ? -rt_data : rt_data;
        product  = {iterHi, iterLo};
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        result_d      = result_q;
        accHi_d       = accHi_q;
        accLo_d       = accLo_q;
        operand_d     = operand_q;
        negLo_d       = negLo_q;
        negHi_d       = negHi_q;
        resultValid_d = 1'b0;
        divByZero_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d = '0;
                    case (funct)
                        FUNCT_W'(FN_MFHI): begin
                            result_d      = hi_q;
                            resultValid_d = 1'b1;
                        end
                        FUNCT_W'(FN_MFLO): begin
                            result_d      = lo_q;
                            resultValid_d = 1'b1;
                        end
                        FUNCT_W'(FN_MTHI): hi_d = rs_data;
                        FUNCT_W'(FN_MTLO): lo_d = rs_data;
                        FUNCT_W'(FN_MULT), FUNCT_W'(FN_MULTU): begin
                            state_d   = ST_MUL;
                            accHi_d   = '0;
                            accLo_d   = rtMag;
                            operand_d = rsMag;
                            negLo_d   = rsNeg ^ rtNeg;
                        end
                        FUNCT_W'(FN_DIV), FUNCT_W'(FN_DIVU): begin
                            if (rt_data == '0) begin
                                lo_d        = '1;
                                hi_d        = rs_data;
                                divByZero_d = 1'b1;
                            end else begin
                                state_d   = ST_DIV;
                                accHi_d   = '0;
                                accLo_d   = rsMag;
                                operand_d = rtMag;
                                negLo_d   = rsNeg ^ rtNeg;
                                negHi_d   = rsNeg;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                accHi_d = iterHi;
                accLo_d = iterLo;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_ITER) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_MUL) begin
                        {hi_d, lo_d} = negLo_q ? -product : product;
                    end else begin
                        lo_d = negLo_q ? -iterLo : iterLo;
                        hi_d = negHi_q ? -iterHi : iterHi;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            result_q      <= '0;
            accHi_q       <= '0;
            accLo_q       <= '0;
            operand_q     <= '0;
            negLo_q       <= 1'b0;
            negHi_q       <= 1'b0;
            resultValid_q <= 1'b0;
            divByZero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            result_q      <= result_d;
            accHi_q       <= accHi_d;
            accLo_q       <= accLo_d;
            operand_q     <= operand_d;
            negLo_q       <= negLo_d;
            negHi_q       <= negHi_d;
            resultValid_q <= resultValid_d;
            divByZero_q   <= divByZero_d;
        end
    end

    assign issue_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = resultValid_q;
    assign result       = result_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign div_by_zero  = divByZero_q;

endmodule
